ahb_uart_arbiter: RTL
=====================

// Module: ahb_uart_arbiter
// PURPOSE
//  Two-requester AHB-Lite single-transfer master in front of the AHB_APB_UART bridge.
//  Requester 0 is the pipelined RISC-V core's MMIO port; requester 1 is the switch/debug
//  path. Grants are round-robin. Each granted request becomes one NONSEQ transfer
//  (address phase + data phase). Read data and the error status go back to the owner.
// PARAMETERS
//  ADDR_W       32   AHB address width
//  DATA_W       32   AHB data width
//  TIMEOUT_CYC  255  max HREADY_i-low cycles in data phase (only with ARB_TIMEOUT_EN), >=1
// PORTS
//  clk_i             in   1       system clock; all logic on rising edge
//  rst_ni            in   1       asynchronous, active-low reset
//  m{0,1}_req_i      in   1       transfer request; held high until gnt
//  m{0,1}_we_i       in   1       1=write, 0=read
//  m{0,1}_addr_i     in   ADDR_W  transfer address
//  m{0,1}_wdata_i    in   DATA_W  write data
//  m{0,1}_size_i     in   2       HSIZE code (00 byte, 01 half, 10 word)
//  m{0,1}_gnt_o      out  1       1-cycle pulse: request accepted, inputs captured
//  m{0,1}_done_o     out  1       1-cycle pulse: transfer finished
//  m{0,1}_err_o      out  1       pulses with done on HRESP error or timeout
//  m{0,1}_rdata_o    out  DATA_W  last read data; holds until the next read done
//  HSEL_o            out  1       slave select; high in the address and data phases
//  HADDR_o           out  ADDR_W  registered address
//  HWRITE_o          out  1       registered direction
//  HTRANS_o          out  2       10=NONSEQ in the address phase, else 00=IDLE
//  HSIZE_o           out  2       registered size
//  HWDATA_o          out  DATA_W  write data; valid through the whole data phase
//  HREADY_i          in   1       slave HREADYout
//  HRDATA_i          in   DATA_W  slave read data
//  HRESP_i           in   2       slave response; 01=ERROR
//  busy_o            out  1       state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_ni=0): state=IDLE, last_owner=1, every output 0, HTRANS_o=00.
//  - FSM states: IDLE -> ADDR -> DATA -> IDLE.
//  - IDLE, no req: stay in IDLE; bus outputs 0.
//  - IDLE, any req: choose the owner, pulse mN_gnt_o combinationally, register the owner's
//    addr/we/size/wdata, go to ADDR.
//  - Arbitration:
//    - One requester active: that requester wins.
//    - Both active: the requester that is not last_owner wins.
//    - last_owner updates on each grant; after reset m0 wins the first tie.
//  - ADDR (exactly 1 cycle): HSEL_o=1, HTRANS_o=10; then go to DATA.
//  - DATA: HSEL_o=1, HTRANS_o=00, HWDATA_o held.
//    - Wait while HREADY_i=0.
//    - On HREADY_i=1: capture HRDATA_i into the owner's rdata (reads only), go to IDLE.
//    - In the next cycle pulse the owner's done_o; err_o=1 if captured HRESP_i==01.
//  - Latency: req seen in IDLE at cycle k -> gnt k, ADDR k+1, DATA k+2, done >= k+3.
//  - Back-to-back: a new gnt is possible in the IDLE cycle where done pulses, so the minimum
//    issue interval is 3 cycles per transfer.
//  - A request dropped before gnt is never issued. Requests arriving while busy wait.
//  - The non-owner's outputs never change during another requester's transfer.
//  - Write transfers never update rdata_o.
//  - Reset mid-transfer: the transfer is abandoned with no done/err pulse; bus returns to IDLE.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//    - A counter (width $clog2(TIMEOUT_CYC+1)) counts DATA cycles with HREADY_i=0.
//    - The counter clears on entry to DATA.
//    - When count reaches TIMEOUT_CYC: go to IDLE, pulse done_o+err_o to the owner,
//      leave rdata_o unchanged.
//  ARB_TIMEOUT_EN undefined: no counter; DATA waits indefinitely for HREADY_i.
// TESTING
//  1. Assert rst_ni=0 mid-DATA -> all outputs 0 at once, HTRANS_o=00, no done; m0 wins the first tie after release.
//  2. m0 write addr 0x1000_0004, wdata 0xA5, size 00, HREADY_i=1 -> m0_gnt cyc0; HTRANS 10/HADDR 0x1000_0004 cyc1; HWDATA 0xA5 cyc2; m0_done cyc3, err 0.
//  3. m0 and m1 both request continuously for 4 transfers -> grant order m0,m1,m0,m1; each done on the matching port only.
//  4. m1 read 0x1000_0008, HREADY_i low 4 cycles then high with HRDATA_i=0x55 -> m1_done 4 cycles later than test 2; m1_rdata_o=0x55; m0_rdata_o unchanged.
//  5. m0 read with HRESP_i=01 at HREADY_i=1 -> m0_done and m0_err_o both pulse 1 cycle.
//  6. TIMEOUT_CYC=16, HREADY_i stuck 0 -> with ARB_TIMEOUT_EN: done+err 16 cycles into DATA, then IDLE; without the macro: busy_o stays 1, no done.

Source files
------------

// File: rtl/ahb_uart_arbiter.sv
// Two-requester round-robin AHB-Lite single-transfer master for the AHB_APB_UART bridge.
// Optional data-phase timeout is enabled by defining ARB_TIMEOUT_EN.
module ahb_uart_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic [1:0]        m0_size_i,
    output logic              m0_gnt_o,
    output logic              m0_done_o,
    output logic              m0_err_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic [1:0]        m1_size_i,
    output logic              m1_gnt_o,
    output logic              m1_done_o,
    output logic              m1_err_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              HSEL_o,
    output logic [ADDR_W-1:0] HADDR_o,
    output logic              HWRITE_o,
    output logic [1:0]        HTRANS_o,
    output logic [1:0]        HSIZE_o,
    output logic [DATA_W-1:0] HWDATA_o,
    input  logic              HREADY_i,
    input  logic [DATA_W-1:0] HRDATA_i,
    input  logic [1:0]        HRESP_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state;
    logic              last_owner;
    logic              owner;
    logic              hsel_q;
    logic [ADDR_W-1:0] haddr_q;
    logic              hwrite_q;
    logic [1:0]        htrans_q;
    logic [1:0]        hsize_q;
    logic [DATA_W-1:0] hwdata_q;
    logic [1:0]        done_q;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic req_any;
    logic win;
    logic grant;
    logic timeout;

    always_comb begin
        req_any = m0_req_i | m1_req_i;
        // On a tie the requester that did not own the previous grant wins.
        win     = (m0_req_i && m1_req_i) ? ~last_owner : m1_req_i;
        grant   = rst_ni && (state == IDLE) && req_any;
    end

    assign m0_gnt_o = grant && !win;
    assign m1_gnt_o = grant && win;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned          CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
        end else if (state == ADDR) begin
            wait_cnt <= '0;
        end else if (state == DATA && !HREADY_i) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYC-th consecutive wait cycle so done lands that many cycles into DATA.
    always_comb begin
        timeout = (state == DATA) && !HREADY_i && (wait_cnt == CNT_LAST);
    end
`else
    always_comb begin
        timeout = 1'b0;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            hsel_q     <= 1'b0;
            haddr_q    <= '0;
            hwrite_q   <= 1'b0;
            htrans_q   <= 2'b00;
            hsize_q    <= 2'b00;
            hwdata_q   <= '0;
            done_q     <= '0;
            err_q      <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        owner      <= win;
                        last_owner <= win;
                        hsel_q     <= 1'b1;
                        htrans_q   <= 2'b10;
                        haddr_q    <= win ? m1_addr_i  : m0_addr_i;
                        hwrite_q   <= win ? m1_we_i    : m0_we_i;
                        hsize_q    <= win ? m1_size_i  : m0_size_i;
                        hwdata_q   <= win ? m1_wdata_i : m0_wdata_i;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    htrans_q <= 2'b00;
                    state    <= DATA;
                end
                DATA: begin
                    if (HREADY_i || timeout) begin
                        done_q[owner] <= 1'b1;
                        err_q[owner]  <= timeout || (HRESP_i == 2'b01);
                        if (HREADY_i && !hwrite_q) begin
                            if (owner) rdata1_q <= HRDATA_i;
                            else       rdata0_q <= HRDATA_i;
                        end
                        // Bus outputs are cleared so IDLE presents an all-zero bus.
                        hsel_q   <= 1'b0;
                        haddr_q  <= '0;
                        hwrite_q <= 1'b0;
                        hsize_q  <= 2'b00;
                        hwdata_q <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign HSEL_o     = hsel_q;
    assign HADDR_o    = haddr_q;
    assign HWRITE_o   = hwrite_q;
    assign HTRANS_o   = htrans_q;
    assign HSIZE_o    = hsize_q;
    assign HWDATA_o   = hwdata_q;
    assign busy_o     = hsel_q;
    assign m0_done_o  = done_q[0];
    assign m1_done_o  = done_q[1];
    assign m0_err_o   = err_q[0];
    assign m1_err_o   = err_q[1];
    assign m0_rdata_o = rdata0_q;
    assign m1_rdata_o = rdata1_q;

endmodule
